npc_gen: RTL and testbench
==========================

Name: npc_gen

Overview:
- Next-PC generator: drives npc_in and halt into the PC register.
- Consumes pc, npc (pc+4) and jpc_head back from the PC register, plus redirect requests from the decode/execute/exception stages of the 8-stage pipeline.
- Holds redirects that arrive while fetch is stalled, and emits a wrong-path flush window after each accepted redirect.
- Implements stall by re-presenting pc on npc_in, because halt in the PC register is sticky.

Parameters:
- FLUSH_CYCLES, 3, cycles flush stays high after an accepted redirect (fetch stages younger than the resolve stage); legal range 1..15.
- EXC_VECTOR, 32'h00400004, exception entry address.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- pc_clk  in  1  clock
- reset  in  1  synchronous, active-high
- pc  in  32  current PC from the PC register
- npc  in  32  pc+4 from the PC register
- jpc_head  in  4  pc[31:28] from the PC register
- stall  in  1  fetch stall; PC must not advance
- br_taken  in  1  conditional branch resolved taken
- br_target  in  32  branch target
- j_valid  in  1  J/JAL resolved
- j_index  in  26  instruction index field
- jr_valid  in  1  JR/JALR resolved
- jr_target  in  32  register target
- exc_valid  in  1  exception raised
- halt_req  in  1  halt instruction retired
- npc_in  out  32  next PC to the PC register
- halt  out  1  to the PC register
- flush  out  1  kill wrong-path fetch stages
- addr_err  out  1  one-cycle pulse: misaligned target
- redirect_cnt  out  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (synchronous, pc_clk): pend_valid=0, pend_target=0, flush=0, flush_cnt=0, halt=0, addr_err=0, redirect_cnt=0. npc_in is combinational, and equals npc while reset is high.
- Target selection, fixed priority: exc_valid > jr_valid > br_taken > j_valid.
  - exc_valid target: EXC_VECTOR.
  - jr_valid target: jr_target.
  - br_taken target: br_target.
  - j_valid target: {jpc_head, j_index, 2'b00}.
  - The selected request is the "new redirect".
- Misalignment:
  - If the selected target has [1:0] != 0, force [1:0]=0 before use.
  - Pulse addr_err for 1 cycle, on the cycle after the request.
  - Exception targets never flag.
- npc_in (combinational), first match wins:
  1. halt or halt_req: pc.
  2. stall: pc.
  3. New redirect present: its target.
  4. pend_valid: pend_target.
  5. Otherwise: npc.
- Pending latch:
  - New redirect while stall=1 and not halting: pend_target <= target, pend_valid <= 1. A newer one overwrites.
  - When stall=0 and npc_in comes from pend_target or a new redirect: pend_valid <= 0.
  - A new redirect with stall=0 supersedes any pending target.
- Accept: a redirect is accepted on the cycle npc_in carries it, i.e. stall=0 and not halting.
- Flush counter:
  - On accept: flush_cnt <= FLUSH_CYCLES and flush is high from the next cycle.
  - flush = (flush_cnt != 0).
  - flush_cnt decrements each cycle stall=0; holds while stall=1.
  - A new accept reloads flush_cnt to FLUSH_CYCLES.
- redirect_cnt: +1 per accept; saturates at all-ones.
- halt:
  - halt_req sets halt <= 1, sticky until reset.
  - Once halt=1 (or halt_req high), redirects are ignored, pend_valid is held, redirect_cnt is frozen, and flush continues to count down to 0.
- Simultaneous halt_req and redirect: halt wins; the redirect is not accepted.
- Reset mid-flush or with a redirect pending: all state clears the next edge; no residual flush.

Test Plan:
- Sequential run:
  - Stimulus: after reset release, pc=0x00400000, npc=0x00400004, no requests.
  - Response: npc_in=0x00400004; flush=0; redirect_cnt=0.
- Jump:
  - Stimulus: j_valid=1, j_index=26'h0100010, jpc_head=4'h0, stall=0.
  - Response: npc_in=0x00400040 that cycle; flush=1 for exactly 3 following cycles; redirect_cnt=1.
- Priority:
  - Stimulus: exc_valid, jr_valid (jr_target=0x00400100) and br_taken (br_target=0x00400200) all asserted together.
  - Response: npc_in=0x00400004 (EXC_VECTOR).
- Stall hold:
  - Stimulus: br_taken with br_target=0x00400080 while stall=1; hold stall 2 cycles; drop the request; release stall.
  - Response: npc_in=pc during the stall; npc_in=0x00400080 on the release cycle; flush starts the next cycle; pend_valid=0 after.
- Misaligned target:
  - Stimulus: jr_target=0x00400103.
  - Response: npc_in=0x00400100; addr_err high for 1 cycle.
- Halt:
  - Stimulus: halt_req together with br_taken.
  - Response: npc_in=pc; halt stays 1; later redirects produce npc_in=pc and redirect_cnt unchanged; reset clears halt.

Source files
------------

// File: rtl/npc_gen.sv
// Next-PC generator: selects redirect targets by priority, parks redirects seen under stall,
// and drives the wrong-path flush window, halt and redirect statistics for the PC register.
module npc_gen #(
   parameter int unsigned FLUSH_CYCLES = 3,
   parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             pc_clk,
   input  logic             reset,
   input  logic [31:0]      pc,
   input  logic [31:0]      npc,
   input  logic [3:0]       jpc_head,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             j_valid,
   input  logic [25:0]      j_index,
   input  logic             jr_valid,
   input  logic [31:0]      jr_target,
   input  logic             exc_valid,
   input  logic             halt_req,
   output logic [31:0]      npc_in,
   output logic             halt,
   output logic             flush,
   output logic             addr_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   logic        halting;
   logic        new_redirect;
   logic        misaligned;
   logic        accept;
   logic [31:0] raw_target;
   logic [31:0] target;
   logic        pend_valid;
   logic [31:0] pend_target;
   logic [3:0]  flush_cnt;

   assign halting      = halt | halt_req;
   assign new_redirect = exc_valid | jr_valid | br_taken | j_valid;

   always_comb begin
      raw_target = '0;
      if (exc_valid)     raw_target = EXC_VECTOR;
      else if (jr_valid) raw_target = jr_target;
      else if (br_taken) raw_target = br_target;
      else if (j_valid)  raw_target = {jpc_head, j_index, 2'b00};
   end

   // Exception vector is trusted; only register/branch targets can be misaligned.
   assign misaligned = new_redirect && !exc_valid && (raw_target[1:0] != 2'b00);
   assign target     = {raw_target[31:2], 2'b00};

   // Pending target counts as accepted on the first unstalled, non-halting cycle.
   assign accept = !halting && !stall && (new_redirect || pend_valid);

   always_comb begin
      npc_in = npc;
      if (reset)             npc_in = npc;
      else if (halting)      npc_in = pc;
      else if (stall)        npc_in = pc;
      else if (new_redirect) npc_in = target;
      else if (pend_valid)   npc_in = pend_target;
   end

   always_ff @(posedge pc_clk) begin
      if (reset) begin
         pend_valid   <= 1'b0;
         pend_target  <= '0;
         flush_cnt    <= '0;
         halt         <= 1'b0;
         addr_err     <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         addr_err <= misaligned && !halting;
         if (halt_req) halt <= 1'b1;

         if (!halting) begin
            if (new_redirect && stall) begin
               pend_valid  <= 1'b1;
               pend_target <= target;
            end else if (accept) begin
               pend_valid  <= 1'b0;
            end
         end

         if (accept)                         flush_cnt <= FLUSH_LOAD;
         else if (!stall && flush_cnt != '0) flush_cnt <= flush_cnt - 4'd1;

         if (accept && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
      end
   end

   assign flush = (flush_cnt != '0);

endmodule

// File: tb/tb_npc_gen.sv
// Bench for npc_gen: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a cycle-level reference model.
module tb_npc_gen;

   localparam int unsigned CW  = 4;
   localparam int unsigned FLC = 3;
   localparam logic [31:0] EXC = 32'h00400004;

   logic          pc_clk = 1'b0;
   logic          reset;
   logic [31:0]   pc, npc;
   logic [3:0]    jpc_head;
   logic          stall, br_taken, j_valid, jr_valid, exc_valid, halt_req;
   logic [31:0]   br_target, jr_target;
   logic [25:0]   j_index;
   logic [31:0]   npc_in;
   logic          halt, flush, addr_err;
   logic [CW-1:0] redirect_cnt;

   npc_gen #(.FLUSH_CYCLES(FLC), .EXC_VECTOR(EXC), .CNT_W(CW)) dut (
      .pc_clk(pc_clk), .reset(reset), .pc(pc), .npc(npc), .jpc_head(jpc_head),
      .stall(stall), .br_taken(br_taken), .br_target(br_target), .j_valid(j_valid),
      .j_index(j_index), .jr_valid(jr_valid), .jr_target(jr_target),
      .exc_valid(exc_valid), .halt_req(halt_req), .npc_in(npc_in), .halt(halt),
      .flush(flush), .addr_err(addr_err), .redirect_cnt(redirect_cnt)
   );

   always #5 pc_clk = ~pc_clk;

   int unsigned n_pass = 0, n_total = 0;

   // reference model state
   bit          m_known = 0;
   bit          m_pend_v, m_halt, m_aerr;
   logic [31:0] m_pend_t;
   int unsigned m_flush, m_cnt;
   logic [31:0] e_npc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   function automatic logic [31:0] req_target(output bit any, output bit mis);
      logic [31:0] t;
      any = 1; t = '0;
      if (exc_valid)     t = EXC;
      else if (jr_valid) t = jr_target;
      else if (br_taken) t = br_target;
      else if (j_valid)  t = {jpc_head, j_index, 2'b00};
      else               any = 0;
      mis = any && !exc_valid && (t % 4 != 0);
      return t - (t % 4);
   endfunction

   task automatic settle();
      bit any, mis, halting;
      logic [31:0] t;
      #3;
      t = req_target(any, mis);
      halting = m_halt || halt_req;
      if (reset)        e_npc = npc;
      else if (halting) e_npc = pc;
      else if (stall)   e_npc = pc;
      else if (any)     e_npc = t;
      else if (m_pend_v) e_npc = m_pend_t;
      else              e_npc = npc;
      if (m_known) begin
         chk("npc_in", npc_in, e_npc);
         chk("halt", 32'(halt), 32'(m_halt));
         chk("flush", 32'(flush), 32'(m_flush != 0));
         chk("addr_err", 32'(addr_err), 32'(m_aerr));
         chk("redirect_cnt", 32'(redirect_cnt), m_cnt);
      end
   endtask

   task automatic advance();
      bit any, mis, halting, acc;
      logic [31:0] t;
      t = req_target(any, mis);
      halting = m_halt || halt_req;
      if (reset) begin
         m_known = 1; m_pend_v = 0; m_pend_t = '0; m_flush = 0;
         m_halt = 0; m_aerr = 0; m_cnt = 0;
      end else begin
         acc    = !halting && !stall && (any || m_pend_v);
         m_aerr = mis && !halting;
         if (!halting) begin
            if (any && stall) begin m_pend_v = 1; m_pend_t = t; end
            else if (acc) m_pend_v = 0;
         end
         if (acc) m_flush = FLC;
         else if (!stall && m_flush > 0) m_flush--;
         if (acc && m_cnt < (1 << CW) - 1) m_cnt++;
         if (halt_req) m_halt = 1;
      end
      @(posedge pc_clk);
      #1;
      pc = e_npc;
      npc = pc + 32'd4;
      jpc_head = pc[31:28];
   endtask

   task automatic clear_reqs();
      br_taken = 0; j_valid = 0; jr_valid = 0; exc_valid = 0; halt_req = 0;
   endtask

   initial begin
      logic [31:0] saved_cnt, saved_pc;
      reset = 1; stall = 0; clear_reqs();
      br_target = '0; jr_target = '0; j_index = '0;
      pc = 32'h00400000; npc = 32'h00400004; jpc_head = 4'h0;
      #1;
      settle(); advance();
      settle(); advance();
      reset = 0;
      pc = 32'h00400000; npc = 32'h00400004; jpc_head = 4'h0;

      // sequential fetch
      settle();
      chk("seq_npc_in", npc_in, 32'h00400004);
      chk("seq_flush", 32'(flush), 32'd0);
      chk("seq_cnt", 32'(redirect_cnt), 32'd0);
      advance();

      // jump: flush for exactly FLC cycles afterwards
      j_valid = 1; j_index = 26'h0100010;
      settle();
      chk("jump_npc_in", npc_in, 32'h00400040);
      advance();
      clear_reqs();
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("jump_flush", 32'(flush), 32'(i < 3));
         if (i == 0) chk("jump_cnt", 32'(redirect_cnt), 32'd1);
         advance();
      end

      // priority: exception beats jr and branch
      exc_valid = 1; jr_valid = 1; jr_target = 32'h00400100;
      br_taken = 1; br_target = 32'h00400200;
      settle();
      chk("prio_npc_in", npc_in, 32'h00400004);
      advance();
      clear_reqs();

      // branch arrives under stall and is held until release
      stall = 1; br_taken = 1; br_target = 32'h00400080;
      saved_pc = pc;
      settle();
      chk("stall_npc_in0", npc_in, saved_pc);
      advance();
      br_taken = 0;
      settle();
      chk("stall_npc_in1", npc_in, saved_pc);
      advance();
      stall = 0;
      settle();
      chk("stall_release", npc_in, 32'h00400080);
      advance();
      settle();
      chk("stall_flush", 32'(flush), 32'd1);
      chk("stall_pend_clr", npc_in, 32'h00400084);
      advance();

      // misaligned register target
      jr_valid = 1; jr_target = 32'h00400103;
      settle();
      chk("mis_npc_in", npc_in, 32'h00400100);
      advance();
      clear_reqs();
      settle();
      chk("mis_aerr_hi", 32'(addr_err), 32'd1);
      advance();
      settle();
      chk("mis_aerr_lo", 32'(addr_err), 32'd0);
      advance();

      // halt wins over a simultaneous branch and freezes redirects
      halt_req = 1; br_taken = 1; br_target = 32'h00400200;
      saved_pc = pc;
      settle();
      chk("halt_npc_in", npc_in, saved_pc);
      advance();
      clear_reqs();
      saved_cnt = 32'(redirect_cnt);
      j_valid = 1; j_index = 26'h0000100;
      settle();
      chk("halt_sticky", 32'(halt), 32'd1);
      chk("halt_ignore", npc_in, saved_pc);
      advance();
      clear_reqs();
      settle();
      chk("halt_cnt", 32'(redirect_cnt), saved_cnt);
      reset = 1;
      advance();
      reset = 0;
      settle();
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      advance();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         reset     = ($urandom_range(0, 119) == 0);
         stall     = ($urandom_range(0, 9) < 3);
         halt_req  = ($urandom_range(0, 199) == 0);
         exc_valid = ($urandom_range(0, 19) == 0);
         jr_valid  = ($urandom_range(0, 7) == 0);
         br_taken  = ($urandom_range(0, 5) == 0);
         j_valid   = ($urandom_range(0, 5) == 0);
         jr_target = $urandom;
         br_target = $urandom;
         j_index   = 26'($urandom);
         settle();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
